// File: rtl/uart_freq_cmd_pkg.sv
// Shared constants for the UART frequency command parser: ASCII codes,
// response bytes and the parser state encoding.
package uart_freq_cmd_pkg;

  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_9    = 8'h39;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] RESP_OK    = 8'h4B;  // 'K'
  localparam logic [7:0] RESP_ERR   = 8'h45;  // 'E'

  localparam int ACC_W = 17;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FLUSH = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/uart_freq_cmd.sv
// Parses ASCII decimal divider commands from a UART byte stream, updates the
// PWM step divider when the value is in range, and answers each command with 'K' or 'E'.
module uart_freq_cmd
  import uart_freq_cmd_pkg::*;
#(
  parameter int CLK_HZ      = 25000000,
  parameter int MAX_DIGITS  = 4,
  parameter int TIMEOUT_CYC = 25000000,
  parameter int DIV_MIN     = 100,
  parameter int DIV_MAX     = 9999,
  parameter int DIV_DEFAULT = 1600
) (
  input  logic        clk1,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_busy,
  output logic        tx_en,
  output logic [7:0]  tx_data,
  output logic [15:0] div_value,
  output logic        div_valid,
  output logic        cmd_err
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_DIGITS);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [ACC_W-1:0] DIV_MIN_A = ACC_W'(DIV_MIN);
  localparam logic [ACC_W-1:0] DIV_MAX_A = ACC_W'(DIV_MAX);
  localparam logic [15:0]      DIV_DEF_A = 16'(DIV_DEFAULT);

  if (CLK_HZ <= 0 || TIMEOUT_CYC < 2 || MAX_DIGITS < 1 || DIV_MAX > 65535 ||
      DIV_MIN > DIV_MAX) begin : g_bad_params
    $error("uart_freq_cmd: illegal parameter combination");
  end

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] digit_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [7:0]       resp_byte;

  logic             is_digit;
  logic             is_term;
  logic [ACC_W-1:0] acc_next;
  logic             in_range;
  logic             tmo_hit;

  always_comb begin
    is_digit = (rx_data >= ASCII_0) && (rx_data <= ASCII_9);
    is_term  = (rx_data == ASCII_CR) || (rx_data == ASCII_LF);
    // Digit values 0x30..0x39 carry their numeric value in the low nibble.
    acc_next = (acc * ACC_W'(10)) + {{(ACC_W-4){1'b0}}, rx_data[3:0]};
    in_range = (acc >= DIV_MIN_A) && (acc <= DIV_MAX_A);
    tmo_hit  = !rx_valid && (tmo_cnt == TMO_LAST);
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state     <= ST_IDLE;
      acc       <= '0;
      digit_cnt <= '0;
      tmo_cnt   <= '0;
      resp_byte <= 8'h00;
      tx_en     <= 1'b0;
      tx_data   <= 8'h00;
      div_value <= DIV_DEF_A;
      div_valid <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      tx_en     <= 1'b0;
      div_valid <= 1'b0;
      cmd_err   <= 1'b0;

      // Inter-byte idle counter only runs while a command is partially received.
      if (rx_valid || state == ST_IDLE || state == ST_RESP) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      case (state)
        ST_IDLE, ST_ACCUM: begin
          if (rx_valid) begin
            if (is_digit) begin
              if (digit_cnt == CNT_MAX) begin
                resp_byte <= RESP_ERR;
                state     <= ST_FLUSH;
              end else begin
                acc       <= acc_next;
                digit_cnt <= digit_cnt + 1'b1;
                state     <= ST_ACCUM;
              end
            end else if (is_term) begin
              // A lone terminator in IDLE is the second half of a CRLF pair.
              if (state == ST_ACCUM) begin
                if (in_range) begin
                  div_value <= acc[15:0];
                  div_valid <= 1'b1;
                  resp_byte <= RESP_OK;
                end else begin
                  cmd_err   <= 1'b1;
                  resp_byte <= RESP_ERR;
                end
                state <= ST_RESP;
              end
            end else begin
              resp_byte <= RESP_ERR;
              state     <= ST_FLUSH;
            end
          end else if (state == ST_ACCUM && tmo_hit) begin
            acc       <= '0;
            digit_cnt <= '0;
            tmo_cnt   <= '0;
            state     <= ST_IDLE;
          end
        end

        ST_FLUSH: begin
          if (rx_valid && is_term) begin
            cmd_err <= 1'b1;
            state   <= ST_RESP;
          end else if (tmo_hit) begin
            acc       <= '0;
            digit_cnt <= '0;
            tmo_cnt   <= '0;
            state     <= ST_IDLE;
          end
        end

        ST_RESP: begin
          // Received bytes are dropped here; the reply waits for the transmitter.
          if (!tx_busy) begin
            tx_en     <= 1'b1;
            tx_data   <= resp_byte;
            acc       <= '0;
            digit_cnt <= '0;
            state     <= ST_IDLE;
          end
        end

        default: begin
          acc       <= '0;
          digit_cnt <= '0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_freq_cmd.sv
// Directed bench for uart_freq_cmd: command strings with hand-computed
// divider values, response bytes and pulse counts.
module tb_uart_freq_cmd;

  localparam int TMO = 50;

  logic        clk1 = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_busy = 1'b0;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic [15:0] div_value;
  logic        div_valid;
  logic        cmd_err;

  int n_chk = 0;
  int n_pass = 0;

  int tx_cnt = 0;
  int dv_cnt = 0;
  int err_cnt = 0;
  int viol_cnt = 0;
  logic [7:0] last_tx = 8'h00;
  logic prev_tx = 1'b0, prev_dv = 1'b0, prev_err = 1'b0;

  uart_freq_cmd #(
    .CLK_HZ(25000000), .MAX_DIGITS(4), .TIMEOUT_CYC(TMO),
    .DIV_MIN(100), .DIV_MAX(9999), .DIV_DEFAULT(1600)
  ) dut (
    .clk1(clk1), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_busy(tx_busy), .tx_en(tx_en), .tx_data(tx_data),
    .div_value(div_value), .div_valid(div_valid), .cmd_err(cmd_err)
  );

  always #5 clk1 = ~clk1;

  always @(negedge clk1) begin
    if (tx_en) begin
      tx_cnt  <= tx_cnt + 1;
      last_tx <= tx_data;
    end
    if (div_valid) dv_cnt <= dv_cnt + 1;
    if (cmd_err) err_cnt <= err_cnt + 1;
    if ((tx_en && prev_tx) || (div_valid && prev_dv) || (cmd_err && prev_err) ||
        (div_valid && cmd_err))
      viol_cnt <= viol_cnt + 1;
    prev_tx  <= tx_en;
    prev_dv  <= div_valid;
    prev_err <= cmd_err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk1);
    rx_valid = 1'b0;
    @(negedge clk1);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  // Send a command, let it settle, then compare pulse deltas and outputs.
  task automatic run_cmd(input string tag, input string s, input int exp_dv,
                         input int exp_err, input int exp_tx,
                         input logic [7:0] exp_byte, input logic [15:0] exp_div);
    int tx0, dv0, err0;
    tx0 = tx_cnt; dv0 = dv_cnt; err0 = err_cnt;
    send_str(s);
    idle(8);
    check({tag, ".div_valid_cnt"}, dv_cnt - dv0, exp_dv);
    check({tag, ".cmd_err_cnt"}, err_cnt - err0, exp_err);
    check({tag, ".tx_cnt"}, tx_cnt - tx0, exp_tx);
    if (exp_tx > 0) check({tag, ".tx_byte"}, last_tx, exp_byte);
    check({tag, ".div_value"}, div_value, exp_div);
  endtask

  initial begin
    int tx0;
    idle(3);
    // Reset state, with a byte offered during reset that must be ignored.
    rx_data = "9"; rx_valid = 1'b1;
    @(negedge clk1);
    rx_valid = 1'b0;
    check("rst.tx_en", tx_en, 0);
    check("rst.tx_data", tx_data, 8'h00);
    check("rst.div_value", div_value, 1600);
    check("rst.div_valid", div_valid, 0);
    check("rst.cmd_err", cmd_err, 0);
    rst = 1'b0;
    idle(2);

    run_cmd("too_many", "12345\r", 0, 1, 1, 8'h45, 1600);
    run_cmd("below_min", "50\r\n", 0, 1, 1, 8'h45, 1600);

    // "825\r" with cycle-exact latency checks.
    send_str("825");
    rx_data = 8'h0D; rx_valid = 1'b1;
    @(negedge clk1);
    rx_valid = 1'b0;
    check("825.div_valid_next", div_valid, 1);
    check("825.div_value", div_value, 825);
    check("825.cmd_err", cmd_err, 0);
    @(negedge clk1);
    check("825.tx_en", tx_en, 1);
    check("825.tx_data", tx_data, 8'h4B);
    @(negedge clk1);
    check("825.tx_en_single", tx_en, 0);
    idle(4);

    run_cmd("bad_char", "4x1\r", 0, 1, 1, 8'h45, 825);
    run_cmd("after_flush", "415\n", 1, 0, 1, 8'h4B, 415);
    run_cmd("at_min", "100\r", 1, 0, 1, 8'h4B, 100);
    run_cmd("at_max", "9999\r", 1, 0, 1, 8'h4B, 9999);
    run_cmd("min_minus1", "99\r", 0, 1, 1, 8'h45, 9999);
    run_cmd("lone_crlf", "\r\n", 0, 0, 0, 8'h00, 9999);

    // Stale partial command times out silently.
    tx0 = tx_cnt;
    send_str("33");
    idle(TMO + 10);
    check("timeout.no_tx", tx_cnt - tx0, 0);
    run_cmd("after_timeout", "556\r", 1, 0, 1, 8'h4B, 556);

    // Gaps shorter than the timeout keep the command alive.
    send_str("1");
    idle(TMO - 10);
    run_cmd("short_gap", "000\r", 1, 0, 1, 8'h4B, 1000);

    // Timeout from FLUSH also returns silently to IDLE.
    tx0 = tx_cnt;
    send_str("z");
    idle(TMO + 10);
    check("flush_timeout.no_tx", tx_cnt - tx0, 0);
    run_cmd("after_flush_tmo", "777\r", 1, 0, 1, 8'h4B, 777);

    // Transmitter busy: reply waits, then goes out on the first free cycle.
    tx_busy = 1'b1;
    tx0 = tx_cnt;
    send_str("2000\r");
    idle(100);
    check("busy.held", tx_cnt - tx0, 0);
    check("busy.div_value", div_value, 2000);
    tx_busy = 1'b0;
    @(negedge clk1);
    check("busy.release_tx_en", tx_en, 1);
    check("busy.release_tx_data", tx_data, 8'h4B);
    idle(4);

    // Reset while waiting in RESP aborts the reply.
    tx_busy = 1'b1;
    tx0 = tx_cnt;
    send_str("700\r");
    idle(10);
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    tx_busy = 1'b0;
    idle(10);
    check("rst_resp.no_tx", tx_cnt - tx0, 0);
    check("rst_resp.div_value", div_value, 1600);
    run_cmd("after_rst", "300\r", 1, 0, 1, 8'h4B, 300);

    check("pulse_rules", viol_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
